// File: rtl/fsm_table_engine_if.sv
// Bundle of run/condition/configuration inputs and status outputs for fsm_table_engine.
// The master modport drives stimulus and configuration; the slave modport is the engine.
interface fsm_table_engine_if #(
    parameter int SW = 4,
    parameter int NI = 2,
    parameter int NO = 9,
    parameter int CW = 16
);
    logic              run;
    logic [NI-1:0]     x;
    logic              cfg_we;
    logic [SW+NI-1:0]  cfg_addr;
    logic [SW+NO-1:0]  cfg_data;
    logic              err_clr;
    logic [NO-1:0]     q;
    logic [SW-1:0]     state;
    logic              err;
    logic [CW-1:0]     steps;

    modport master (
        output run, x, cfg_we, cfg_addr, cfg_data, err_clr,
        input  q, state, err, steps
    );

    modport slave (
        input  run, x, cfg_we, cfg_addr, cfg_data, err_clr,
        output q, state, err, steps
    );
endinterface

// File: rtl/fsm_table_engine.sv
// Table-driven Mealy automaton: next state and outputs come from a writable table
// indexed by {state, x}, with sticky invalid-entry flag and saturating step counter.
module fsm_table_engine #(
    parameter int SW      = 4,
    parameter int NI      = 2,
    parameter int NO      = 9,
    parameter int OUT_REG = 0,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               res,
    fsm_table_engine_if.slave  bus
);
    localparam int AW    = SW + NI;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = SW + NO;

    logic [EW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [SW-1:0] state_q, state_d;
    logic          err_q, err_d;
    logic [CW-1:0] steps_q, steps_d;
    logic [NO-1:0] q_d;

    logic [AW-1:0] idx;
    logic [EW-1:0] ent;
    logic          hit;

    assign idx = {state_q, bus.x};
    assign ent = mem[idx];
    assign hit = vld_q[idx];

    // Entry data is never reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && !res) begin
            mem[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vld_q <= '0;
        end else if (bus.cfg_we) begin
            vld_q[bus.cfg_addr] <= 1'b1;
        end
    end

    // Lookup sees the pre-write table, so a same-cycle write takes effect next cycle.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        steps_d = steps_q;
        q_d     = '0;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (bus.run) begin
            if (hit) begin
                state_d = ent[EW-1:NO];
                q_d     = ent[NO-1:0];
                if (steps_q != {CW{1'b1}}) begin
                    steps_d = steps_q + CW'(1);
                end
            end else begin
                state_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= '0;
            err_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            steps_q <= steps_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_qreg
            logic [NO-1:0] q_q;
            always_ff @(posedge clk or posedge res) begin
                if (res) begin
                    q_q <= '0;
                end else begin
                    q_q <= q_d;
                end
            end
            assign bus.q = q_q;
        end else begin : g_qcomb
            assign bus.q = q_d;
        end
    endgenerate

    assign bus.state = state_q;
    assign bus.err   = err_q;
    assign bus.steps = steps_q;
endmodule

// File: tb/tb_fsm_table_engine.sv
// Directed bench driving a combinational-output engine (CW=4) and a registered-output
// engine (CW=16) in lockstep; expectations go through a scoreboard queue.
module tb_fsm_table_engine;
    logic        clk = 1'b0;
    logic        res;
    logic        run;
    logic [1:0]  x;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [12:0] cfg_data;
    logic        err_clr;

    always #5 clk = ~clk;

    fsm_table_engine_if #(.SW(4), .NI(2), .NO(9), .CW(4))  ifa ();
    fsm_table_engine_if #(.SW(4), .NI(2), .NO(9), .CW(16)) ifb ();

    assign ifa.run = run;      assign ifb.run = run;
    assign ifa.x = x;          assign ifb.x = x;
    assign ifa.cfg_we = cfg_we;     assign ifb.cfg_we = cfg_we;
    assign ifa.cfg_addr = cfg_addr; assign ifb.cfg_addr = cfg_addr;
    assign ifa.cfg_data = cfg_data; assign ifb.cfg_data = cfg_data;
    assign ifa.err_clr = err_clr;   assign ifb.err_clr = err_clr;

    fsm_table_engine #(.SW(4), .NI(2), .NO(9), .OUT_REG(0), .CW(4)) dut_a (
        .clk(clk), .res(res), .bus(ifa.slave)
    );
    fsm_table_engine #(.SW(4), .NI(2), .NO(9), .OUT_REG(1), .CW(16)) dut_b (
        .clk(clk), .res(res), .bus(ifb.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input logic [1:0] xx, input int ns, input logic [8:0] o);
        cfg_we   = 1'b1;
        cfg_addr = {4'(s), xx};
        cfg_data = {4'(ns), o};
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        logic [8:0] prevq;
        logic [8:0] curq;
        res = 1'b1; run = 1'b0; x = 2'b00; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; err_clr = 1'b0;
        tick(); tick();

        // Reset state
        push("rst_a_state", 0); push("rst_a_q", 0); push("rst_b_q", 0);
        push("rst_a_err", 0);   push("rst_a_steps", 0);
        chk(32'(ifa.state)); chk(32'(ifa.q)); chk(32'(ifb.q));
        chk(32'(ifa.err));   chk(32'(ifa.steps));

        // Empty table: first edge after release flags an invalid entry
        run = 1'b1; x = 2'b00; res = 1'b0;
        tick();
        push("empty_a_err", 1); push("empty_a_state", 0);
        push("empty_a_steps", 0); push("empty_b_err", 1);
        chk(32'(ifa.err)); chk(32'(ifa.state)); chk(32'(ifa.steps)); chk(32'(ifb.err));

        run = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        push("clr0_a_err", 0); push("clr0_b_err", 0);
        chk(32'(ifa.err)); chk(32'(ifb.err));

        for (int s = 0; s < 10; s++) begin
            wr(s, 2'b01, (s + 1) % 10, 9'(1 << (s % 9)));
        end

        // Ten-state loop
        run = 1'b1; x = 2'b01; prevq = '0;
        for (int k = 0; k < 12; k++) begin
            curq = 9'(1 << ((k % 10) % 9));
            push("loop_a_state", 32'(k % 10));
            push("loop_a_q", 32'(curq));
            push("loop_b_q", 32'(prevq));
            #1;
            chk(32'(ifa.state)); chk(32'(ifa.q)); chk(32'(ifb.q));
            prevq = curq;
            tick();
        end
        push("loop_a_state_end", 2); push("loop_a_steps", 12);
        push("loop_b_steps", 12);    push("loop_b_q_end", 32'(prevq));
        chk(32'(ifa.state)); chk(32'(ifa.steps)); chk(32'(ifb.steps)); chk(32'(ifb.q));

        // run=0 holds state and zeroes outputs
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            push("hold_b_q", 0); push("hold_b_state", 2); push("hold_a_q", 0);
            chk(32'(ifb.q)); chk(32'(ifb.state)); chk(32'(ifa.q));
        end

        // Write collision at state 3
        run = 1'b1; x = 2'b01;
        tick();
        cfg_we = 1'b1; cfg_addr = {4'd3, 2'b01}; cfg_data = {4'd7, 9'h1FF};
        #1;
        push("coll_a_q_old", 32'h008);
        chk(32'(ifa.q));
        tick();
        cfg_we = 1'b0;
        push("coll_a_state", 4); push("coll_b_q", 32'h008);
        chk(32'(ifa.state)); chk(32'(ifb.q));

        repeat (9) tick();
        push("ret_a_state", 3); push("sat_a_steps", 15); push("ret_b_steps", 23);
        chk(32'(ifa.state)); chk(32'(ifa.steps)); chk(32'(ifb.steps));
        #1;
        push("new_a_q", 32'h1FF);
        chk(32'(ifa.q));
        tick();
        push("new_a_state", 7); push("new_b_q", 32'h1FF);
        push("sat2_a_steps", 15); push("new_b_steps", 24);
        chk(32'(ifa.state)); chk(32'(ifb.q)); chk(32'(ifa.steps)); chk(32'(ifb.steps));

        // Invalid entry {5,10} and err clear
        run = 1'b0;
        wr(7, 2'b01, 5, 9'h055);
        wr(3, 2'b01, 4, 9'h008);
        run = 1'b1; x = 2'b01;
        tick();
        push("to5_a_state", 5); push("to5_b_q", 32'h055);
        chk(32'(ifa.state)); chk(32'(ifb.q));
        x = 2'b10;
        #1;
        push("inv_a_q", 0);
        chk(32'(ifa.q));
        tick();
        push("inv_a_state", 0); push("inv_a_err", 1); push("inv_a_steps", 15);
        push("inv_b_steps", 25); push("inv_b_q", 0);
        chk(32'(ifa.state)); chk(32'(ifa.err)); chk(32'(ifa.steps));
        chk(32'(ifb.steps)); chk(32'(ifb.q));
        err_clr = 1'b1;
        tick();
        push("setwins_a_err", 1); push("setwins_a_state", 0);
        chk(32'(ifa.err)); chk(32'(ifa.state));
        run = 1'b0;
        tick();
        err_clr = 1'b0;
        push("clr_a_err", 0); push("clr_b_err", 0);
        chk(32'(ifa.err)); chk(32'(ifb.err));

        // Asynchronous reset at state 6
        run = 1'b1; x = 2'b01;
        repeat (6) tick();
        push("pre_a_state", 6); push("pre_a_q", 32'h040); push("pre_b_q", 32'h020);
        chk(32'(ifa.state)); chk(32'(ifa.q)); chk(32'(ifb.q));
        #3;
        res = 1'b1;
        #1;
        push("arst_a_state", 0); push("arst_a_q", 0); push("arst_b_q", 0);
        push("arst_b_state", 0); push("arst_b_steps", 0);
        chk(32'(ifa.state)); chk(32'(ifa.q)); chk(32'(ifb.q));
        chk(32'(ifb.state)); chk(32'(ifb.steps));

        // Write during reset is discarded
        cfg_we = 1'b1; cfg_addr = {4'd0, 2'b00}; cfg_data = {4'd1, 9'h001};
        x = 2'b00;
        tick();
        cfg_we = 1'b0; res = 1'b0;
        tick();
        push("drop_a_err", 1); push("drop_a_state", 0);
        chk(32'(ifa.err)); chk(32'(ifa.state));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
